// File: rtl/fcmp_if.sv
// rtl/fcmp_if.sv - operand/result stream bundle for the pipelined float comparator
interface fcmp_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] x1;
  logic [W-1:0] x2;
  logic [1:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic         y;
  logic         invalid;
  logic         inv_sticky;
  logic         inv_clr;

  modport master (
    output in_valid, x1, x2, op, out_ready, inv_clr,
    input  in_ready, out_valid, y, invalid, inv_sticky
  );

  modport slave (
    input  in_valid, x1, x2, op, out_ready, inv_clr,
    output in_ready, out_valid, y, invalid, inv_sticky
  );
endinterface

// File: rtl/fcmp_pipe.sv
// rtl/fcmp_pipe.sv - pipelined IEEE-754 EQ/LT/LE/UNORD comparator with invalid flag
module fcmp_pipe #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int LATENCY = 2
) (
  input logic  clk,
  input logic  rst,
  fcmp_if.slave bus
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam logic [1:0] OP_EQ    = 2'd0;
  localparam logic [1:0] OP_LT    = 2'd1;
  localparam logic [1:0] OP_LE    = 2'd2;
  localparam logic [1:0] OP_UNORD = 2'd3;

  logic         a_sign, b_sign;
  logic [W-2:0] a_mag, b_mag;
  logic         a_nan, b_nan, a_snan, b_snan, a_zero, b_zero;
  logic         any_nan, any_snan, both_zero, eq, lt;
  logic         res_y, res_inv;

  always_comb begin
    a_sign    = bus.x1[W-1];
    b_sign    = bus.x2[W-1];
    a_mag     = bus.x1[W-2:0];
    b_mag     = bus.x2[W-2:0];
    a_nan     = (&bus.x1[W-2:MAN_W]) && (|bus.x1[MAN_W-1:0]);
    b_nan     = (&bus.x2[W-2:MAN_W]) && (|bus.x2[MAN_W-1:0]);
    a_snan    = a_nan && !bus.x1[MAN_W-1];
    b_snan    = b_nan && !bus.x2[MAN_W-1];
    a_zero    = ~|a_mag;
    b_zero    = ~|b_mag;
    any_nan   = a_nan || b_nan;
    any_snan  = a_snan || b_snan;
    both_zero = a_zero && b_zero;
    eq        = both_zero || (bus.x1 == bus.x2);
    // Sign-magnitude ordering: on negatives the larger magnitude is the smaller value.
    if (both_zero)           lt = 1'b0;
    else if (a_sign != b_sign) lt = a_sign;
    else if (!a_sign)        lt = a_mag < b_mag;
    else                     lt = a_mag > b_mag;

    res_y = 1'b0;
    if (any_nan) begin
      res_y = (bus.op == OP_UNORD);
    end else begin
      case (bus.op)
        OP_EQ:   res_y = eq;
        OP_LT:   res_y = lt;
        OP_LE:   res_y = lt || eq;
        default: res_y = 1'b0;
      endcase
    end
    res_inv = ((bus.op == OP_LT) || (bus.op == OP_LE)) ? any_nan : any_snan;
  end

  // Index 0 is the first stage, LATENCY-1 drives the outputs.
  logic [LATENCY-1:0] v_q, v_d, y_q, y_d, inv_q, inv_d, load;
  logic               sticky_q, sticky_d;
  logic               full_run, out_fire;

  always_comb begin
    full_run = 1'b1;
    for (int k = LATENCY - 1; k >= 0; k--) begin
      full_run = full_run && v_q[k];
      load[k]  = !full_run || bus.out_ready;
    end

    v_d   = v_q;
    y_d   = y_q;
    inv_d = inv_q;
    if (load[0]) begin
      v_d[0] = bus.in_valid;
      if (bus.in_valid) begin
        y_d[0]   = res_y;
        inv_d[0] = res_inv;
      end
    end
    for (int k = 1; k < LATENCY; k++) begin
      if (load[k]) begin
        v_d[k]   = v_q[k-1];
        y_d[k]   = y_q[k-1];
        inv_d[k] = inv_q[k-1];
      end
    end

    out_fire = v_q[LATENCY-1] && !rst && bus.out_ready;
    sticky_d = (bus.inv_clr ? 1'b0 : sticky_q) || (out_fire && inv_q[LATENCY-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q      <= '0;
      y_q      <= '0;
      inv_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      v_q      <= v_d;
      y_q      <= y_d;
      inv_q    <= inv_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.in_ready   = load[0] && !rst;
  assign bus.out_valid  = v_q[LATENCY-1] && !rst;
  assign bus.y          = y_q[LATENCY-1];
  assign bus.invalid    = inv_q[LATENCY-1];
  assign bus.inv_sticky = sticky_q;
endmodule

// File: tb/tb_fcmp_pipe.sv
// tb/tb_fcmp_pipe.sv - scoreboard bench for fcmp_pipe against a real-valued reference
module tb_fcmp_pipe;
  localparam int LA = 2;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic real to_real(input int ew, input int mw, input logic [31:0] v);
    int  e, m, bias;
    real mag;
    e    = int'((v >> mw) & ((32'd1 << ew) - 1));
    m    = int'(v & ((32'd1 << mw) - 1));
    bias = (1 << (ew - 1)) - 1;
    if (e == (1 << ew) - 1)  mag = $pow(2.0, 1000.0);
    else if (e == 0)         mag = real'(m) * $pow(2.0, real'(1 - bias - mw));
    else                     mag = (real'(m) + $pow(2.0, real'(mw))) * $pow(2.0, real'(e - bias - mw));
    return v[ew+mw] ? -mag : mag;
  endfunction

  task automatic model(input int ew, input int mw, input logic [31:0] a, input logic [31:0] b,
                       input logic [1:0] o, output logic ry, output logic rinv);
    logic [31:0] ea, eb, ma, mb, emax;
    bit  na, nb, sa, sb;
    real ra, rb;
    emax = (32'd1 << ew) - 1;
    ea = (a >> mw) & emax;  eb = (b >> mw) & emax;
    ma = a & ((32'd1 << mw) - 1);  mb = b & ((32'd1 << mw) - 1);
    na = (ea == emax) && (ma != 0);  nb = (eb == emax) && (mb != 0);
    sa = na && !ma[mw-1];  sb = nb && !mb[mw-1];
    ra = to_real(ew, mw, a);  rb = to_real(ew, mw, b);
    if (na || nb) ry = (o == 2'd3);
    else case (o)
      2'd0: ry = (ra == rb);
      2'd1: ry = (ra < rb);
      2'd2: ry = (ra <= rb);
      default: ry = 1'b0;
    endcase
    rinv = (o == 2'd1 || o == 2'd2) ? (na || nb) : (sa || sb);
  endtask

  function automatic logic [31:0] mdir(input int mw, input int idx);
    case (idx)
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'd2;
      3: return 32'd7 << (mw - 4);
      4: return 32'd1 << (mw - 1);
      5: return (32'd1 << (mw - 1)) - 1;
      default: return (32'd1 << mw) - 1;
    endcase
  endfunction

  function automatic logic [31:0] rnd(input int ew, input int mw);
    logic [31:0] s, e, m;
    s = $urandom % 2;
    case ($urandom % 4)
      0: e = 0;
      1: e = (32'd1 << ew) - 1;
      default: e = $urandom % (32'd1 << ew);
    endcase
    m = ($urandom % 2 != 0) ? mdir(mw, $urandom % 7) : ($urandom & ((32'd1 << mw) - 1));
    return (s << (ew + mw)) | (e << mw) | m;
  endfunction

  function automatic logic [31:0] pair(input int ew, input int mw, input logic [31:0] a);
    int k;
    case ($urandom % 8)
      0: return a;
      1: return a ^ (32'd1 << (ew + mw));
      2, 3: begin
        k = $urandom_range(1, mw);
        return a ^ ($urandom & ((32'd1 << k) - 1));
      end
      default: return rnd(ew, mw);
    endcase
  endfunction

  // ---------------- main DUT: 8/23, latency 2 ----------------
  fcmp_if #(.EXP_W(8), .MAN_W(23)) ifa ();
  fcmp_pipe #(.EXP_W(8), .MAN_W(23), .LATENCY(LA)) dut (.clk(clk), .rst(rst), .bus(ifa));

  typedef struct { logic y; logic inv; int acc; bit lat; } exp_t;
  exp_t q[$];
  int   cyc = 0;
  int   outs = 0;
  bit   prev_rst = 0;
  bit   chk_lat = 0;
  logic exp_sticky = 0;
  int   bp_mode = 0;
  int   stall_left = 0;
  bit   gen_go = 0;

  always begin
    exp_t e;
    bit   fire_inv;
    @(negedge clk);
    #4;
    cyc++;
    if (rst) begin
      q.delete();
      exp_sticky = 1'b0;
      prev_rst   = 1'b1;
    end else begin
      if (prev_rst) chk("post_reset_out_valid", ifa.out_valid, 0);
      prev_rst = 1'b0;
      chk("in_ready", ifa.in_ready, (q.size() < LA || ifa.out_ready) ? 1 : 0);
      chk("inv_sticky", ifa.inv_sticky, exp_sticky);
      fire_inv = 0;
      if (ifa.out_valid && ifa.out_ready) begin
        if (q.size() == 0) begin
          chk("spurious_output", 1, 0);
        end else begin
          e = q.pop_front();
          outs++;
          chk("y", ifa.y, e.y);
          chk("invalid", ifa.invalid, e.inv);
          if (e.lat) chk("latency", cyc - e.acc, LA);
          fire_inv = e.inv;
        end
      end
      exp_sticky = (ifa.inv_clr ? 1'b0 : exp_sticky) | fire_inv;
      if (ifa.in_valid && ifa.in_ready) begin
        model(8, 23, ifa.x1, ifa.x2, ifa.op, e.y, e.inv);
        e.acc = cyc;
        e.lat = chk_lat;
        q.push_back(e);
      end
    end
  end

  task automatic set_ready();
    if (stall_left > 0) begin
      ifa.out_ready = 1'b0;
      stall_left--;
    end else if (bp_mode != 0) ifa.out_ready = ($urandom % 4) != 0;
    else ifa.out_ready = 1'b1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [1:0] o);
    bit acc;
    int n;
    ifa.in_valid = 1'b1;
    ifa.x1 = a;
    ifa.x2 = b;
    ifa.op = o;
    set_ready();
    n = 0;
    do begin
      #4;
      acc = ifa.in_ready;
      @(negedge clk);
      n++;
      if (!acc) set_ready();
    end while (!acc && n < 200);
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    ifa.in_valid = 1'b0;
    repeat (n) begin
      set_ready();
      @(negedge clk);
    end
  endtask

  // ---------------- sweep DUTs: 5/10 lat 4 and 8/23 lat 1 ----------------
  for (genvar g = 0; g < 2; g++) begin : gen_cfg
    localparam int EW = (g == 0) ? 5 : 8;
    localparam int MW = (g == 0) ? 10 : 23;
    localparam int LT = (g == 0) ? 4 : 1;
    fcmp_if #(.EXP_W(EW), .MAN_W(MW)) bi ();
    fcmp_pipe #(.EXP_W(EW), .MAN_W(MW), .LATENCY(LT)) u_dut (.clk(clk), .rst(rst), .bus(bi));

    exp_t gq[$];
    bit   done_g = 0;

    initial begin
      logic [31:0] a;
      bit acc;
      int n, tries;
      bi.in_valid = 1'b0;  bi.out_ready = 1'b0;  bi.inv_clr = 1'b0;
      bi.x1 = '0;  bi.x2 = '0;  bi.op = 2'd0;
      wait (gen_go);
      n = 0;  tries = 0;  acc = 0;
      while (n < 300 && tries < 5000) begin
        @(negedge clk);
        tries++;
        bi.out_ready = ($urandom % 4) != 0;
        if (!bi.in_valid || acc) begin
          bi.in_valid = ($urandom % 5) != 0;
          a = rnd(EW, MW);
          bi.x1 = a[EW+MW:0];
          a = pair(EW, MW, a);
          bi.x2 = a[EW+MW:0];
          bi.op = 2'($urandom % 4);
        end
        #4;
        acc = bi.in_valid && bi.in_ready;
        if (acc) n++;
      end
      @(negedge clk);
      bi.in_valid  = 1'b0;
      bi.out_ready = 1'b1;
      repeat (LT + 4) @(negedge clk);
      done_g = 1;
    end

    always begin
      exp_t e;
      @(negedge clk);
      #4;
      if (rst) gq.delete();
      else if (gen_go) begin
        chk("in_ready_g", bi.in_ready, (gq.size() < LT || bi.out_ready) ? 1 : 0);
        if (bi.out_valid && bi.out_ready) begin
          if (gq.size() == 0) chk("spurious_output_g", 1, 0);
          else begin
            e = gq.pop_front();
            chk("y_g", bi.y, e.y);
            chk("invalid_g", bi.invalid, e.inv);
          end
        end
        if (bi.in_valid && bi.in_ready) begin
          model(EW, MW, 32'(bi.x1), 32'(bi.x2), bi.op, e.y, e.inv);
          gq.push_back(e);
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] a;
    int outs0, t;
    rst = 1'b1;
    ifa.in_valid = 1'b0;  ifa.out_ready = 1'b1;  ifa.inv_clr = 1'b0;
    ifa.x1 = '0;  ifa.x2 = '0;  ifa.op = 2'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #4;
    chk("rst_out_valid", ifa.out_valid, 0);
    chk("rst_y", ifa.y, 0);
    chk("rst_invalid", ifa.invalid, 0);
    chk("rst_inv_sticky", ifa.inv_sticky, 0);
    chk("rst_in_ready", ifa.in_ready, 1);
    @(negedge clk);

    chk_lat = 1;
    send(32'h3F800000, 32'h40000000, 2'd2);
    idle(4);
    send(32'h80000000, 32'h00000000, 2'd2);
    send(32'h80000000, 32'h00000000, 2'd0);
    send(32'h80000000, 32'h00000000, 2'd1);
    send(32'h80000001, 32'h00000001, 2'd1);
    send(32'h807FFFFF, 32'h80000001, 2'd1);
    send(32'h7FC00000, 32'h3F800000, 2'd0);
    send(32'h7FC00000, 32'h3F800000, 2'd3);
    send(32'h7FC00000, 32'h3F800000, 2'd2);
    send(32'h7F800000, 32'hFF800000, 2'd1);
    idle(4);
    send(32'h7F800001, 32'h3F800000, 2'd0);
    idle(4);
    ifa.inv_clr = 1'b1;
    idle(1);
    ifa.inv_clr = 1'b0;
    idle(2);

    chk_lat = 0;
    outs0 = outs;
    for (int i = 0; i < 3; i++) send(rnd(8, 23), rnd(8, 23), 2'($urandom % 4));
    idle(1);
    stall_left = 5;
    for (int i = 0; i < 5; i++) send(rnd(8, 23), rnd(8, 23), 2'($urandom % 4));
    idle(12);
    chk("bp_count", outs - outs0, 8);

    send(32'h3F800000, 32'h40000000, 2'd1);
    send(32'h7F800001, 32'h40000000, 2'd2);
    ifa.in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_lat = 1;
    send(32'hC0000000, 32'h40000000, 2'd2);
    idle(5);
    chk_lat = 0;

    gen_go = 1;
    bp_mode = 1;
    for (int e = 0; e < 256; e++) begin
      a = (32'($urandom % 2) << 31) | (32'(e) << 23) | mdir(23, $urandom % 7);
      send(a, pair(8, 23, a), 2'($urandom % 4));
    end
    for (int i = 0; i < 200; i++) begin
      a = rnd(8, 23);
      send(a, pair(8, 23, a), 2'($urandom % 4));
      if ($urandom % 6 == 0) idle(1);
    end
    bp_mode = 0;
    idle(10);

    t = 0;
    while (!(gen_cfg[0].done_g && gen_cfg[1].done_g) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk("gen_done", (gen_cfg[0].done_g && gen_cfg[1].done_g) ? 1 : 0, 1);
    chk("drain_a", q.size(), 0);
    chk("drain_g0", gen_cfg[0].gq.size(), 0);
    chk("drain_g1", gen_cfg[1].gq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
